cv32e40x_clmul_seq: RTL and testbench
=====================================

// Module: cv32e40x_clmul_seq
// PURPOSE
//  Iterative, multi-cycle carry-less multiply unit for the B-extension ALU path.
//  Computes clmul / clmulh / clmulr on a shared shift-XOR accumulator.
//  Processes BITS_PER_CYCLE multiplier bits per clock instead of a 32-deep XOR tree.
//  Sits beside the ALU; the EX stage issues to it and retires from it via valid/ready.
// PARAMETERS
//  BITS_PER_CYCLE  4  multiplier bits consumed per BUSY cycle; one of 1,2,4,8,16,32.
//                     ITER = 32/BITS_PER_CYCLE.
// PORTS
//  clk         in   1   clock
//  rst_n       in   1   synchronous reset, active-low
//  kill_i      in   1   flush; aborts any operation in flight
//  valid_i     in   1   operation request
//  ready_o     out  1   request accepted when valid_i && ready_o
//  op_a_i      in   32  multiplicand
//  op_b_i      in   32  multiplier
//  operator_i  in   2   00=clmul, 10=clmulr, 01/11=clmulh
//  valid_o     out  1   result available
//  ready_i     in   1   result consumed when valid_o && ready_i
//  result_o    out  32  selected product slice
//  busy_o      out  1   1 in BUSY or DONE
// BEHAVIOUR
//  Clocking/reset
//   - Single clock; all state updates on the rising edge.
//   - rst_n is synchronous, active-low.
//   - Reset values: state=IDLE, ready_o=1, valid_o=0, busy_o=0, result_o=0,
//     accumulator=0, counter=0.
//   - Reset asserted mid-operation returns to IDLE at the next edge; the result is discarded.
//  States
//   - IDLE: ready_o=1. On valid_i && !kill_i:
//       latch op_a and operator;
//       acc[63:0] = {32'b0, op_b};
//       cnt = ITER-1;
//       go to BUSY.
//   - BUSY: ready_o=0. Each edge performs BITS_PER_CYCLE sequential steps:
//       if acc[0], then acc[63:32] ^= op_a;
//       then acc >>= 1 (logical shift).
//       If cnt==0, go to DONE; otherwise cnt--.
//   - DONE: valid_o=1, ready_o=0. Go to IDLE on ready_i.
//       result_o and valid_o are held stable while ready_i=0, with no limit on stall length.
//  Result
//   - After 32 steps, acc[62:0] is the 63-bit carry-less product and acc[63]=0.
//   - result_o selects from acc:
//       00 -> acc[31:0]
//       10 -> acc[62:31]
//       01/11 -> acc[63:32]
//   - result_o is 0 whenever valid_o=0.
//  Latency
//   - The accept cycle is cycle 0. BUSY occupies cycles 1..ITER.
//   - valid_o=1 from cycle ITER+1; default is cycle 9.
//   - No back-to-back issue: the next accept happens no earlier than the cycle after the DONE handshake.
//  Inputs ignored after accept
//   - op_a_i, op_b_i and operator_i are ignored after the accept cycle.
//  kill_i
//   - kill_i has highest priority among inputs; only rst_n outranks it.
//   - In any state, the next state is IDLE and valid_o is 0 at the next edge.
//   - A request presented with kill_i=1 in IDLE is not accepted (ready_o stays 1, no state change).
//   - kill_i and ready_i both high in DONE: returns to IDLE and counts as a consumed result.
//  Edge cases
//   - op_a=0 or op_b=0 gives result 0 for all operators; the full ITER latency still applies.
// TESTING
//  1. BPC=4: a=0x3, b=0x3, op=00 -> valid_o at cycle 9, result 0x00000005; ready_o=0 in cycles 1..9.
//  2. a=b=0x80000000:
//       op=00 -> 0x00000000
//       op=01 -> 0x40000000
//       op=10 -> 0x80000000
//  3. a=b=0xFFFFFFFF, op=00 -> 0x55555555; op=11 -> 0x55555555.
//  4. Hold ready_i=0 for 5 cycles in DONE -> result_o and valid_o stable.
//     Toggling op_a_i/valid_i meanwhile has no effect.
//     Pulse ready_i -> IDLE, ready_o=1 the next cycle.
//  5. Pulse kill_i at cycle 4 of BUSY -> IDLE next edge, valid_o never rises.
//     A fresh request with a=0x5, b=0x3, op=00 then yields 0x0000000F.
//  6. Drop rst_n for one cycle during BUSY -> all outputs at reset values next cycle.
//     Repeat tests 1-3 with BPC=1 (latency 33) and BPC=32 (latency 2).

Source files
------------

// File: rtl/cv32e40x_clmul_seq.sv
// Iterative carry-less multiplier (clmul/clmulh/clmulr) built on a shift-XOR accumulator.
// Rev 1.0 - initial release.
`default_nettype none

module cv32e40x_clmul_seq #(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        kill_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [1:0]  operator_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic        busy_o
);

  localparam int ITER  = 32 / BITS_PER_CYCLE;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [63:0]        acc;
  logic [63:0]        acc_nxt;
  logic [63:0]        acc_step;
  logic [31:0]        op_a;
  logic [1:0]         oper;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               accept;

  // Multiplier bits live in the low half and shift out; partial products enter at the top.
  always_comb begin
    acc_step = acc;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (acc_step[0]) begin
        acc_step[63:32] = acc_step[63:32] ^ op_a;
      end
      acc_step = acc_step >> 1;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    if (kill_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            accept    = 1'b1;
            state_nxt = BUSY;
            acc_nxt   = {32'b0, op_b_i};
            cnt_nxt   = CNT_W'(ITER - 1);
          end
        end
        BUSY: begin
          acc_nxt = acc_step;
          if (cnt == '0) begin
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (ready_i) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      op_a  <= '0;
      oper  <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        op_a <= op_a_i;
        oper <= operator_i;
      end
    end
  end

  assign ready_o = (state == IDLE);
  assign valid_o = (state == DONE);
  assign busy_o  = (state != IDLE);

  always_comb begin
    result_o = '0;
    if (state == DONE) begin
      case (oper)
        2'b00:   result_o = acc[31:0];
        2'b10:   result_o = acc[62:31];
        default: result_o = acc[63:32];
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cv32e40x_clmul_seq.sv
// Bench for cv32e40x_clmul_seq: three instances (1, 4 and 32 bits per cycle) against a bit-level model.
`default_nettype none

module tb_cv32e40x_clmul_seq;

  logic        clk = 1'b0;
  logic        rst_n    [3];
  logic        kill     [3];
  logic        valid_in [3];
  logic        ready_in [3];
  logic [31:0] a_in     [3];
  logic [31:0] b_in     [3];
  logic [1:0]  op_in    [3];
  logic        rdy      [3];
  logic        vld      [3];
  logic        bsy      [3];
  logic [31:0] res      [3];

  int checks   = 0;
  int failures = 0;

  int          m_left [3];
  bit          m_done [3];
  logic [31:0] m_res  [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cv32e40x_clmul_seq #(
      .BITS_PER_CYCLE((g == 0) ? 1 : ((g == 1) ? 4 : 32))
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n[g]),
      .kill_i     (kill[g]),
      .valid_i    (valid_in[g]),
      .ready_o    (rdy[g]),
      .op_a_i     (a_in[g]),
      .op_b_i     (b_in[g]),
      .operator_i (op_in[g]),
      .valid_o    (vld[g]),
      .ready_i    (ready_in[g]),
      .result_o   (res[g]),
      .busy_o     (bsy[g])
    );
  end

  function automatic int bpc_of(int k);
    return (k == 0) ? 1 : ((k == 1) ? 4 : 32);
  endfunction

  function automatic int iter_of(int k);
    return 32 / bpc_of(k);
  endfunction

  // Product as the XOR of shifted copies of a, one per set bit of b.
  function automatic logic [31:0] clmul_ref(logic [31:0] a, logic [31:0] b, logic [1:0] op);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) p = p ^ ({32'b0, a} << i);
    end
    case (op)
      2'b00:   return p[31:0];
      2'b10:   return p[62:31];
      default: return p[63:32];
    endcase
  endfunction

  task automatic check(string name, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s bpc=%0d got=%h expected=%h", name, bpc_of(k), act, exp);
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n[k] || kill[k]) begin
        m_left[k] <= 0;
        m_done[k] <= 1'b0;
      end else if (m_left[k] == 0 && !m_done[k]) begin
        if (valid_in[k]) begin
          m_left[k] <= iter_of(k);
          m_res[k]  <= clmul_ref(a_in[k], b_in[k], op_in[k]);
        end
      end else if (m_left[k] > 0) begin
        m_left[k] <= m_left[k] - 1;
        if (m_left[k] == 1) m_done[k] <= 1'b1;
      end else if (ready_in[k]) begin
        m_done[k] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      automatic bit idle = (m_left[k] == 0) && !m_done[k];
      check("model_ready",  k, 32'(rdy[k]), 32'(idle));
      check("model_busy",   k, 32'(bsy[k]), 32'(!idle));
      check("model_valid",  k, 32'(vld[k]), 32'(m_done[k]));
      check("model_result", k, res[k], m_done[k] ? m_res[k] : 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one request and waits for valid_o; returns the cycle index of valid_o.
  task automatic issue_and_wait(int k, logic [31:0] a, logic [31:0] b, logic [1:0] op,
                                output int cyc, output bit ready_seen);
    a_in[k] = a; b_in[k] = b; op_in[k] = op; valid_in[k] = 1'b1;
    tick();
    valid_in[k] = 1'b0;
    a_in[k] = 32'hDEAD_BEEF; b_in[k] = 32'h1234_5678; op_in[k] = ~op;
    cyc = 1;
    ready_seen = 1'b0;
    while (!vld[k] && cyc < 100) begin
      if (rdy[k]) ready_seen = 1'b1;
      tick();
      cyc++;
    end
  endtask

  task automatic run_op(int k, logic [31:0] a, logic [31:0] b, logic [1:0] op, logic [31:0] exp);
    int  cyc;
    bit  rs;
    issue_and_wait(k, a, b, op, cyc, rs);
    check("latency", k, 32'(cyc), 32'(iter_of(k) + 1));
    check("ready_low_in_busy", k, 32'(rs), 32'd0);
    check("result", k, res[k], exp);
    ready_in[k] = 1'b1;
    tick();
    ready_in[k] = 1'b0;
    check("ready_after_handshake", k, 32'(rdy[k]), 32'd1);
  endtask

  initial begin
    int  cyc;
    bit  rs;
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; kill[k] = 1'b0; valid_in[k] = 1'b0; ready_in[k] = 1'b0;
      a_in[k] = '0; b_in[k] = '0; op_in[k] = '0;
      m_left[k] = 0; m_done[k] = 1'b0; m_res[k] = '0;
    end
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      check("reset_ready",  k, 32'(rdy[k]), 32'd1);
      check("reset_valid",  k, 32'(vld[k]), 32'd0);
      check("reset_busy",   k, 32'(bsy[k]), 32'd0);
      check("reset_result", k, res[k], 32'h0);
      rst_n[k] = 1'b1;
    end
    tick();

    for (int k = 0; k < 3; k++) begin
      run_op(k, 32'h3, 32'h3, 2'b00, 32'h0000_0005);
      run_op(k, 32'h8000_0000, 32'h8000_0000, 2'b00, 32'h0000_0000);
      run_op(k, 32'h8000_0000, 32'h8000_0000, 2'b01, 32'h4000_0000);
      run_op(k, 32'h8000_0000, 32'h8000_0000, 2'b10, 32'h8000_0000);
      run_op(k, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'h5555_5555);
      run_op(k, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'h5555_5555);
      run_op(k, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 32'hAAAA_AAAA);
      run_op(k, 32'h0, 32'h1234_5678, 2'b01, 32'h0);
      run_op(k, 32'hCAFE_F00D, 32'h0, 2'b00, 32'h0);
    end

    // Long stall in DONE with noise on the request side.
    issue_and_wait(1, 32'h7, 32'h3, 2'b00, cyc, rs);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid",  1, 32'(vld[1]), 32'd1);
      check("stall_result", 1, res[1], 32'h0000_0009);
      a_in[1] = a_in[1] + 32'h1111;
      valid_in[1] = ~valid_in[1];
      tick();
    end
    valid_in[1] = 1'b0;
    ready_in[1] = 1'b1;
    tick();
    ready_in[1] = 1'b0;
    check("stall_release_ready", 1, 32'(rdy[1]), 32'd1);
    check("stall_release_valid", 1, 32'(vld[1]), 32'd0);

    // Kill in the fourth BUSY cycle.
    a_in[1] = 32'h9; b_in[1] = 32'h9; op_in[1] = 2'b00; valid_in[1] = 1'b1;
    tick();
    valid_in[1] = 1'b0;
    tick(); tick(); tick();
    kill[1] = 1'b1;
    tick();
    kill[1] = 1'b0;
    check("kill_ready", 1, 32'(rdy[1]), 32'd1);
    check("kill_busy",  1, 32'(bsy[1]), 32'd0);
    for (int i = 0; i < 10; i++) begin
      check("kill_no_valid", 1, 32'(vld[1]), 32'd0);
      tick();
    end
    run_op(1, 32'h5, 32'h3, 2'b00, 32'h0000_000F);

    // Request with kill held in IDLE is refused.
    a_in[1] = 32'h3; b_in[1] = 32'h3; valid_in[1] = 1'b1; kill[1] = 1'b1;
    tick();
    valid_in[1] = 1'b0; kill[1] = 1'b0;
    check("kill_idle_ready", 1, 32'(rdy[1]), 32'd1);
    check("kill_idle_busy",  1, 32'(bsy[1]), 32'd0);

    // One-cycle reset during BUSY.
    for (int k = 0; k < 3; k += 2) begin
      a_in[k] = 32'h3; b_in[k] = 32'h3; op_in[k] = 2'b00; valid_in[k] = 1'b1;
    end
    a_in[1] = 32'h3; b_in[1] = 32'h3; op_in[1] = 2'b00; valid_in[1] = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) valid_in[k] = 1'b0;
    tick();
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    tick();
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      check("midreset_ready",  k, 32'(rdy[k]), 32'd1);
      check("midreset_valid",  k, 32'(vld[k]), 32'd0);
      check("midreset_busy",   k, 32'(bsy[k]), 32'd0);
      check("midreset_result", k, res[k], 32'h0);
    end
    ready_in[2] = 1'b1;
    tick();
    ready_in[2] = 1'b0;
    run_op(1, 32'h3, 32'h3, 2'b00, 32'h0000_0005);

    // Kill and ready together in DONE.
    issue_and_wait(1, 32'h5, 32'h5, 2'b00, cyc, rs);
    check("kill_done_result", 1, res[1], 32'h0000_0011);
    kill[1] = 1'b1; ready_in[1] = 1'b1;
    tick();
    kill[1] = 1'b0; ready_in[1] = 1'b0;
    check("kill_done_ready", 1, 32'(rdy[1]), 32'd1);
    check("kill_done_valid", 1, 32'(vld[1]), 32'd0);
    run_op(1, 32'h6, 32'h3, 2'b00, 32'h0000_000A);

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
